// File: rtl/cm3_code_axi3_rom_slave.sv
// Read-only AXI3 slave serving the Cortex-M3 CODE port from a synchronous ROM.
// Reads are one outstanding burst at a time; every write is completed with SLVERR.
module cm3_code_axi3_rom_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int          MEM_AW    = 14
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic [31:0]       araddr,
    input  logic [1:0]        arburst,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd4 << MEM_AW);

    // Whole-burst legality: size, alignment, window bounds, burst type and wrap length.
    function automatic logic ar_error(input logic [31:0] addr, input logic [1:0] burst,
                                      input logic [3:0] len, input logic [2:0] size);
        logic [32:0] end_excl;
        logic        bad_wrap;
        if (burst == 2'b01) begin
            end_excl = {1'b0, addr} + (({29'd0, len} + 33'd1) << 2);
        end else begin
            end_excl = {1'b0, addr} + 33'd4;
        end
        bad_wrap = (burst == 2'b10) &&
                   !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return (size != 3'b010) || (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
               (end_excl > WIN_END) || (burst == 2'b11) || bad_wrap;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [3:0] len);
        logic [31:0] wmask;
        wmask = {26'd0, len, 2'b11};
        case (burst)
            2'b01:   return addr + 32'd4;
            2'b10:   return (addr & ~wmask) | ((addr + 32'd4) & wmask);
            default: return addr;
        endcase
    endfunction

    function automatic logic [MEM_AW-1:0] word_addr(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 2);
    endfunction

    rstate_t           rstate_q, rstate_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        burst_q, burst_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              mem_en_q, mem_en_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              ar_err_s;
    logic [31:0]       nxt_addr_s;

    wstate_t           wstate_q, wstate_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              unused_s;
    assign unused_s = ^{awaddr, awlen, awburst, wdata, wstrb};

    assign ar_err_s   = ar_error(araddr, arburst, arlen, arsize);
    assign nxt_addr_s = next_addr(addr_q, burst_q, len_q);

    // Read FSM next state; mem_en is raised on entry to R_ISSUE so it is high for that cycle.
    always_comb begin
        rstate_d   = rstate_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        len_d      = len_q;
        beat_d     = beat_q;
        err_d      = err_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    addr_d   = araddr;
                    burst_d  = arburst;
                    len_d    = arlen;
                    beat_d   = 4'd0;
                    err_d    = ar_err_s;
                    mem_en_d = !ar_err_s;
                    if (!ar_err_s) begin
                        mem_addr_d = word_addr(araddr);
                    end else begin
                        mem_addr_d = mem_addr_q;
                    end
                    rstate_d = R_ISSUE;
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_ISSUE: begin
                rstate_d = R_WAIT;
            end
            R_WAIT: begin
                rdata_d  = err_q ? 32'd0 : mem_rdata;
                rresp_d  = err_q ? 2'b10 : 2'b00;
                rlast_d  = (beat_q == len_q);
                rvalid_d = 1'b1;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        beat_d   = beat_q + 4'd1;
                        addr_d   = nxt_addr_s;
                        mem_en_d = !err_q;
                        if (!err_q) begin
                            mem_addr_d = word_addr(nxt_addr_s);
                        end else begin
                            mem_addr_d = mem_addr_q;
                        end
                        rstate_d = R_ISSUE;
                    end
                end else begin
                    rstate_d = R_DATA;
                end
            end
            default: begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
            end
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    // Read-side registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            rstate_q   <= R_IDLE;
            addr_q     <= 32'd0;
            burst_q    <= 2'b00;
            len_q      <= 4'd0;
            beat_q     <= 4'd0;
            err_q      <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'b00;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            rstate_q   <= rstate_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Write FSM next state; handshake outputs are decoded from the next state and registered.
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wstate_d = W_DATA;
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q && wlast) begin
                    wstate_d = W_RESP;
                end else begin
                    wstate_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    wstate_d = W_IDLE;
                end else begin
                    wstate_d = W_RESP;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
        bvalid_d  = (wstate_d == W_RESP);
        bresp_d   = (wstate_d == W_RESP) ? 2'b10 : 2'b00;
    end

    // Write-side registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rlast    = rlast_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;

endmodule

// File: tb/tb_cm3_code_axi3_rom_slave.sv
// Directed plus randomized bench for the CODE-port ROM slave against a burst-level reference model.
module tb_cm3_code_axi3_rom_slave;

    localparam logic [31:0] BASE   = 32'h0010_0000;
    localparam int          MEM_AW = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       araddr;
    logic [1:0]        arburst;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [31:0]       awaddr;
    logic [3:0]        awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [MEM_AW-1:0] mem_q[$];

    cm3_code_axi3_rom_slave #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW)) dut (
        .sys_clock(clk), .reset(reset),
        .araddr(araddr), .arburst(arburst), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ROM model: data valid only in the cycle after mem_en, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? (32'hC0DE_0000 + {18'd0, mem_addr}) : $urandom();
        if (reset && mem_en) mem_q.push_back(mem_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules for burst legality, address sequence and ROM contents.
    function automatic bit model_err(longint a, int burst, int len, int size);
        longint hi = longint'(BASE) + 4 * (longint'(1) << MEM_AW);
        longint last_byte;
        if (size != 2 || a % 4 != 0 || burst == 3) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (a < longint'(BASE)) return 1'b1;
        last_byte = (burst == 1) ? a + 4 * (len + 1) - 1 : a + 3;
        return last_byte >= hi;
    endfunction

    function automatic longint model_next(longint a, int burst, int len);
        longint w = 4 * (len + 1);
        longint lo = a - (a % w);
        if (burst == 1) return a + 4;
        if (burst == 2) return lo + ((a - lo + 4) % w);
        return a;
    endfunction

    function automatic logic [31:0] rom_word(longint a);
        return 32'(longint'(32'hC0DE_0000) + (a - longint'(BASE)) / 4);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_rlast"}, {31'd0, rlast}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
        chk({tag, "_awready"}, {31'd0, awready}, 32'd0);
        chk({tag, "_wready"}, {31'd0, wready}, 32'd0);
        chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd0);
        chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, {18'd0, mem_addr}, 32'd0);
    endtask

    task automatic ar_issue(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l,
                            input logic [2:0] s);
        int t = 0;
        araddr = a; arburst = b; arlen = l; arsize = s; arvalid = 1'b1;
        while (!arready && t < 20) begin step(); t++; end
        chk("ar_ready", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l,
                           input logic [2:0] s, input int hold, input bit chk_lat);
        bit          err = model_err(longint'(a), int'(b), int'(l), int'(s));
        longint      cur = longint'(a);
        longint      exp_words[$];
        logic [31:0] d0;
        logic        l0;
        int          t;
        mem_q.delete();
        rready = (hold == 0);
        ar_issue(a, b, l, s);
        if (chk_lat) begin
            chk("lat_cycle1", {31'd0, rvalid}, 32'd0);
            step();
            chk("lat_cycle2", {31'd0, rvalid}, 32'd0);
            step();
            chk("lat_cycle3", {31'd0, rvalid}, 32'd1);
        end
        for (int bt = 0; bt <= int'(l); bt++) begin
            rready = (hold == 0);
            t = 0;
            while (!rvalid && t < 30) begin step(); t++; end
            chk("rvalid_seen", {31'd0, rvalid}, 32'd1);
            if (!rvalid) break;
            d0 = rdata;
            l0 = rlast;
            for (int h = 0; h < hold; h++) begin
                step();
                chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
                chk("hold_rdata", rdata, d0);
                chk("hold_rlast", {31'd0, rlast}, {31'd0, l0});
            end
            rready = 1'b1;
            chk("rdata", rdata, err ? 32'd0 : rom_word(cur));
            chk("rresp", {30'd0, rresp}, err ? 32'd2 : 32'd0);
            chk("rlast", {31'd0, rlast}, (bt == int'(l)) ? 32'd1 : 32'd0);
            exp_words.push_back((cur - longint'(BASE)) / 4);
            cur = model_next(cur, int'(b), int'(l));
            step();
        end
        chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
        chk("arready_back", {31'd0, arready}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("no_extra_beat", {31'd0, rvalid}, 32'd0);
        chk("mem_en_count", mem_q.size(), err ? 32'd0 : 32'(int'(l) + 1));
        if (!err && mem_q.size() == int'(l) + 1) begin
            for (int i = 0; i <= int'(l); i++)
                chk("mem_addr", {18'd0, mem_q[i]}, 32'(exp_words[i]));
        end
        rready = 1'b0;
    endtask

    task automatic do_write(input int nbeats, input int bdelay);
        int t = 0;
        awaddr = BASE; awlen = 4'(nbeats - 1); awburst = 2'b01; awvalid = 1'b1;
        while (!awready && t < 20) begin step(); t++; end
        chk("aw_ready", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        wvalid = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            wlast = (i == nbeats - 1);
            wdata = $urandom();
            wstrb = 4'hF;
            t = 0;
            while (!wready && t < 20) begin step(); t++; end
            chk("w_ready", {31'd0, wready}, 32'd1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_done_wready", {31'd0, wready}, 32'd0);
        for (int i = 0; i < bdelay; i++) begin
            chk("b_held_valid", {31'd0, bvalid}, 32'd1);
            chk("b_held_resp", {30'd0, bresp}, 32'd2);
            step();
        end
        bready = 1'b1;
        chk("b_valid", {31'd0, bvalid}, 32'd1);
        step();
        bready = 1'b0;
        chk("b_drop", {31'd0, bvalid}, 32'd0);
        chk("aw_back", {31'd0, awready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; arvalid = 1'b0; araddr = 32'd0; arburst = 2'b01; arlen = 4'd0;
        arsize = 3'd2; rready = 1'b0; awvalid = 1'b0; awaddr = 32'd0; awlen = 4'd0;
        awburst = 2'b01; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0;
        bready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_all_zero("rst");
        reset = 1'b1;
        step();
        chk("post_rst_arready", {31'd0, arready}, 32'd1);
        chk("post_rst_awready", {31'd0, awready}, 32'd1);

        do_read(BASE + 32'h8, 2'b01, 4'd0, 3'd2, 0, 1'b1);
        do_read(BASE + 32'h10, 2'b01, 4'd3, 3'd2, 0, 1'b0);
        do_read(BASE + 32'h0C, 2'b10, 4'd3, 3'd2, 0, 1'b0);
        do_read(BASE + 32'h0C, 2'b10, 4'd3, 3'd2, 5, 1'b0);
        do_read(BASE + 32'h1_0000, 2'b01, 4'd1, 3'd2, 0, 1'b0);
        do_read(BASE, 2'b01, 4'd0, 3'd1, 0, 1'b0);
        do_read(BASE + 32'hFFFC, 2'b01, 4'd1, 3'd2, 0, 1'b0);
        do_read(BASE + 32'hFFFC, 2'b01, 4'd0, 3'd2, 0, 1'b0);
        do_read(BASE + 32'h40, 2'b10, 4'd2, 3'd2, 0, 1'b0);
        do_read(BASE + 32'h44, 2'b11, 4'd1, 3'd2, 0, 1'b0);
        do_read(BASE + 32'h34, 2'b00, 4'd2, 3'd2, 1, 1'b0);
        do_read(BASE - 32'h4, 2'b01, 4'd0, 3'd2, 0, 1'b0);

        fork
            do_write(3, 4);
            do_read(BASE + 32'h40, 2'b01, 4'd3, 3'd2, 0, 1'b0);
        join

        // Reset during beat 2 of an 8-beat INCR burst.
        mem_q.delete();
        rready = 1'b1;
        ar_issue(BASE + 32'h20, 2'b01, 4'd7, 3'd2);
        for (int bt = 0; bt < 2; bt++) begin
            int t = 0;
            while (!rvalid && t < 30) begin step(); t++; end
            chk("rst_burst_rdata", rdata, 32'hC0DE_0008 + 32'(bt));
            step();
        end
        reset = 1'b0;
        step();
        chk_all_zero("midrst");
        reset = 1'b1;
        step();
        chk("midrst_arready", {31'd0, arready}, 32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("midrst_no_beat", {31'd0, rvalid}, 32'd0);
        rready = 1'b0;
        do_read(BASE + 32'h30, 2'b01, 4'd0, 3'd2, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [1:0]  b;
            logic [3:0]  l;
            logic [2:0]  s;
            b = 2'($urandom_range(0, 2));
            l = (b == 2'b10) ? 4'((4 << $urandom_range(0, 2)) - 1) : 4'($urandom_range(0, 7));
            a = BASE + 32'($urandom_range(0, 16383) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'h1;
            if ($urandom_range(0, 7) == 0) a = a + 32'h0001_0000;
            s = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            do_read(a, b, l, s, $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
